// File: rtl/clock_pkg.sv
// Shared definitions for the smart-clock settings path.
//   state_e      : edit sequencer states
//   CS_*         : conf_stat encoding shown on the screen
//   SEC/MIN/HOUR_MAX : BCD wrap limits per field
//   TIME_W       : width of a packed BCD {h,min,sec} value
package clock_pkg;

  localparam int TIME_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEC,
    ST_MIN,
    ST_HOUR,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] CS_IDLE = 2'd0;
  localparam logic [1:0] CS_SEC  = 2'd1;
  localparam logic [1:0] CS_MIN  = 2'd2;
  localparam logic [1:0] CS_HOUR = 2'd3;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational two-digit BCD increment with wrap.
//   val_i : current field value (two BCD digits)
//   lim_i : last legal value of the field; it and anything above wraps to 00
//   val_o : incremented value
// Invalid BCD digits also wrap to 00 so a corrupt field self-heals on the
// first increment.
module bcd_field_inc (
  input  logic [7:0] val_i,
  input  logic [7:0] lim_i,
  output logic [7:0] val_o
);

  logic bad;

  // Raw byte compare is a valid magnitude compare for well-formed BCD.
  assign bad = (val_i[3:0] > 4'd9) || (val_i[7:4] > 4'd9) || (val_i >= lim_i);

  always_comb begin
    val_o = 8'h00;
    if (!bad) begin
      if (val_i[3:0] == 4'd9) val_o = {val_i[7:4] + 4'd1, 4'd0};
      else                    val_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/set_ctrl.sv
// Settings controller: sequences a BCD hh:mm:ss edit (sec -> min -> h ->
// commit) on a shared buffer and commits it to the clock or the alarm.
//   clk, rst_n            : clock, async active-low reset
//   btn_set/btn_mod/btn_sel : one-cycle button pulses
//   cur_time, cur_alarm   : live time / stored alarm, BCD {h,min,sec}
//   conf_stat             : 0 idle/commit, 1 sec, 2 min, 3 h
//   target                : 0 clock, 1 alarm
//   edit_buf              : value under edit, for the screen
//   h_min_sec_once        : commit data, valid with a commit strobe
//   commit_time/commit_alarm : one-cycle load strobes
//   busy                  : any state but IDLE
// Macro SET_CTRL_ALARM_EN enables the alarm target; without it only the
// clock is edited, target and commit_alarm stay 0.
module set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_set,
  input  logic              btn_mod,
  input  logic              btn_sel,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] cur_alarm,
  output logic [1:0]        conf_stat,
  output logic              target,
  output logic [TIME_W-1:0] edit_buf,
  output logic [TIME_W-1:0] h_min_sec_once,
  output logic              commit_time,
  output logic              commit_alarm,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              target_q;
  logic [TIME_W-1:0] edit_buf_q, once_q;
  logic              ct_q, ca_q, busy_q;
  logic [1:0]        conf_q;

  logic [7:0]        sec_nx, min_nx, hour_nx;
  logic [TIME_W-1:0] inc_buf, load_val;

  bcd_field_inc u_sec  (.val_i(edit_buf_q[7:0]),   .lim_i(SEC_MAX),  .val_o(sec_nx));
  bcd_field_inc u_min  (.val_i(edit_buf_q[15:8]),  .lim_i(MIN_MAX),  .val_o(min_nx));
  bcd_field_inc u_hour (.val_i(edit_buf_q[23:16]), .lim_i(HOUR_MAX), .val_o(hour_nx));

  // Only the field under edit changes; no carry into neighbouring fields.
  always_comb begin
    inc_buf = edit_buf_q;
    case (state_q)
      ST_SEC:  inc_buf[7:0]   = sec_nx;
      ST_MIN:  inc_buf[15:8]  = min_nx;
      ST_HOUR: inc_buf[23:16] = hour_nx;
      default: inc_buf = edit_buf_q;
    endcase
  end

`ifdef SET_CTRL_ALARM_EN
  assign load_val = target_q ? cur_alarm : cur_time;
`else
  assign load_val = cur_time;
  logic unused_alarm;
  assign unused_alarm = ^{cur_alarm, btn_sel};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= 1'b0;
      edit_buf_q <= '0;
      once_q     <= '0;
      ct_q       <= 1'b0;
      ca_q       <= 1'b0;
      busy_q     <= 1'b0;
      conf_q     <= CS_IDLE;
    end else begin
      ct_q <= 1'b0;
      ca_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
`ifdef SET_CTRL_ALARM_EN
          if (btn_sel) target_q <= ~target_q;
`endif
          if (btn_set) begin
            edit_buf_q <= load_val;
            state_q    <= ST_SEC;
            conf_q     <= CS_SEC;
            busy_q     <= 1'b1;
          end
        end
        ST_SEC, ST_MIN, ST_HOUR: begin
          // btn_set outranks btn_mod; either one restarts the idle count.
          if (btn_set) begin
            cnt_q <= '0;
            case (state_q)
              ST_SEC: begin
                state_q <= ST_MIN;
                conf_q  <= CS_MIN;
              end
              ST_MIN: begin
                state_q <= ST_HOUR;
                conf_q  <= CS_HOUR;
              end
              default: begin
                state_q <= ST_COMMIT;
                conf_q  <= CS_IDLE;
                once_q  <= edit_buf_q;
                ct_q    <= ~target_q;
                ca_q    <= target_q;
              end
            endcase
          end else if (btn_mod) begin
            cnt_q      <= '0;
            edit_buf_q <= inc_buf;
          end else if (cnt_q == CNT_LAST) begin
            // Abandon the edit silently; edit_buf keeps what was typed.
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            conf_q  <= CS_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          conf_q  <= CS_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign conf_stat      = conf_q;
  assign target         = target_q;
  assign edit_buf       = edit_buf_q;
  assign h_min_sec_once = once_q;
  assign commit_time    = ct_q;
  assign commit_alarm   = ca_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_set_ctrl.sv
module tb_set_ctrl;

  localparam int TO = 16;
`ifdef SET_CTRL_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_set = 1'b0, btn_mod = 1'b0, btn_sel = 1'b0;
  logic [23:0] cur_time = '0, cur_alarm = '0;
  logic [1:0]  conf_stat;
  logic        target, commit_time, commit_alarm, busy;
  logic [23:0] edit_buf, h_min_sec_once;

  int ntests = 0;
  int nfail  = 0;

  set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_mod(btn_mod),
    .btn_sel(btn_sel), .cur_time(cur_time), .cur_alarm(cur_alarm),
    .conf_stat(conf_stat), .target(target), .edit_buf(edit_buf),
    .h_min_sec_once(h_min_sec_once), .commit_time(commit_time),
    .commit_alarm(commit_alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1..3 editing field sec/min/hour, 4 commit.
  int          m_st;
  bit          m_tgt, m_ct, m_ca;
  logic [7:0]  m_f[3];
  logic [23:0] m_once;
  int          cyc, last_act;
  int          lim_dec[3] = '{59, 59, 23};

  function automatic logic [7:0] inc_ref(input logic [7:0] v, input int maxv);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 8'h00;
    d = hi * 10 + lo;
    if (d >= maxv) return 8'h00;
    d = d + 1;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_tgt = 0; m_ct = 0; m_ca = 0;
    m_f[0] = 0; m_f[1] = 0; m_f[2] = 0; m_once = 0;
  endtask

  task automatic model_edge(input bit s, input bit m, input bit l);
    logic [23:0] src;
    cyc++;
    m_ct = 0; m_ca = 0;
    if (m_st == 0) begin
      if (s) begin
        src = m_tgt ? cur_alarm : cur_time;
        m_f[0] = src[7:0]; m_f[1] = src[15:8]; m_f[2] = src[23:16];
        m_st = 1; last_act = cyc;
      end
      if (ALARM_EN && l) m_tgt = !m_tgt;
    end else if (m_st <= 3) begin
      if (s) begin
        last_act = cyc;
        if (m_st == 3) begin
          m_once = {m_f[2], m_f[1], m_f[0]};
          m_ct = !m_tgt; m_ca = m_tgt; m_st = 4;
        end else m_st++;
      end else if (m) begin
        m_f[m_st-1] = inc_ref(m_f[m_st-1], lim_dec[m_st-1]);
        last_act = cyc;
      end else if (cyc - last_act == TO) begin
        m_st = 0;
      end
    end else begin
      m_st = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("conf_stat", 24'(conf_stat), (m_st >= 1 && m_st <= 3) ? 24'(m_st) : 24'd0);
    chk("busy", 24'(busy), 24'(m_st != 0));
    chk("target", 24'(target), 24'(m_tgt));
    chk("edit_buf", edit_buf, {m_f[2], m_f[1], m_f[0]});
    chk("h_min_sec_once", h_min_sec_once, m_once);
    chk("commit_time", 24'(commit_time), 24'(m_ct));
    chk("commit_alarm", 24'(commit_alarm), 24'(m_ca));
  endtask

  task automatic step(input bit s, input bit m, input bit l);
    @(negedge clk);
    btn_set = s; btn_mod = m; btn_sel = l;
    @(posedge clk);
    model_edge(s, m, l);
    #1 check_all();
  endtask

  function automatic logic [7:0] rnd_bcd(input int maxv);
    int d;
    d = $urandom_range(maxv, 0);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  initial begin
    model_reset();
    cyc = 0; last_act = 0;
    #12 check_all();
    chk("reset_edit_buf", edit_buf, 24'h000000);
    @(negedge clk) rst_n = 1'b1;

    // Basic edit: three increments of seconds, commit to clock.
    cur_time = 24'h120000;
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("commit_data", h_min_sec_once, 24'h120003);
    chk("commit_strobe", 24'(commit_time), 24'd1);
    step(0, 0, 0);
    chk("back_idle", 24'(conf_stat), 24'd0);

    // Minute wrap 59 -> 00.
    cur_time = 24'h005900;
    step(1, 0, 0); step(1, 0, 0); step(0, 1, 0);
    chk("min_wrap", edit_buf, 24'h000000);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // Hour wrap 23 -> 00, no carry.
    cur_time = 24'h230000;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 1, 0);
    chk("hour_wrap", edit_buf, 24'h000000);
    step(1, 0, 0); step(0, 0, 0);

    // Invalid BCD nibble wraps to 00.
    cur_time = 24'h1234a7;
    step(1, 0, 0); step(0, 1, 0);
    chk("bad_bcd", edit_buf, 24'h123400);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // Target toggle, full edit, then btn_sel inside SEC is ignored.
    cur_alarm = 24'h063015;
    cur_time  = 24'h101010;
    step(0, 0, 1);
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 1);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    step(0, 0, 1);

    // set + mod together in SEC: advance wins, seconds untouched.
    cur_time = 24'h100005;
    step(1, 0, 0); step(1, 1, 0);
    chk("set_wins_conf", 24'(conf_stat), 24'd2);
    chk("set_wins_sec", 24'(edit_buf[7:0]), 24'h05);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // Timeout with a restart by btn_mod at cycle 10.
    cur_time = 24'h010203;
    step(1, 0, 0);
    repeat (9) step(0, 0, 0);
    step(0, 1, 0);
    repeat (15) step(0, 0, 0);
    chk("to_still_sec", 24'(conf_stat), 24'd1);
    step(0, 0, 0);
    chk("to_idle", 24'(busy), 24'd0);
    chk("to_no_strobe", 24'(commit_time), 24'd0);
    chk("to_buf_kept", edit_buf, 24'h010204);

    // Async reset in HOUR.
    cur_time = 24'h111111;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    btn_set = 0; btn_mod = 0; btn_sel = 0;
    rst_n = 1'b1;
    step(0, 0, 0); step(0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7, 0) == 0)
        cur_time = ($urandom_range(9, 0) == 0) ? 24'($urandom)
                 : {rnd_bcd(23), rnd_bcd(59), rnd_bcd(59)};
      if ($urandom_range(7, 0) == 0)
        cur_alarm = {rnd_bcd(23), rnd_bcd(59), rnd_bcd(59)};
      step($urandom_range(9, 0) == 0, $urandom_range(2, 0) == 0,
           $urandom_range(15, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
